// File: rtl/imem_arbiter_if.sv
// Bus bundle for imem_arbiter: fetch port, loader/debug port and IMEM array port.
// The arbiter takes the slave modport; the environment (fetch, loader, memory) takes master.
interface imem_arbiter_if #(
    parameter int WORD_ADDR_WIDTH = 18,
    parameter int DATA_WIDTH      = 32
);
    // Fetch port
    logic                       f_req;
    logic [31:0]                f_addr;
    logic                       f_flush;
    logic                       f_gnt;
    logic                       f_rvalid;
    logic [DATA_WIDTH-1:0]      f_rdata;
    logic                       f_fault;

    // Loader / debug port
    logic                       l_req;
    logic                       l_we;
    logic [31:0]                l_addr;
    logic [DATA_WIDTH-1:0]      l_wdata;
    logic                       l_gnt;
    logic                       l_rvalid;
    logic [DATA_WIDTH-1:0]      l_rdata;
    logic                       l_fault;

    // IMEM array port
    logic                       mem_en;
    logic                       mem_we;
    logic [WORD_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic [DATA_WIDTH-1:0]      mem_rdata;

    modport slave (
        input  f_req, f_addr, f_flush,
        output f_gnt, f_rvalid, f_rdata, f_fault,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata, l_fault,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr, f_flush,
        input  f_gnt, f_rvalid, f_rdata, f_fault,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata, l_fault,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port IMEM arbiter: fetch has priority, loader wins after STARVE_LIMIT lost contentions.
// Optional performance counters are enabled with the IMEM_ARB_PERF_EN macro.
module imem_arbiter #(
    parameter int WORD_ADDR_WIDTH = 18,
    parameter int DATA_WIDTH      = 32,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_arbiter_if.slave       bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    // Any set bit here means misaligned or outside the byte window.
    localparam logic [31:0] FAULT_MASK =
        ~((32'h1 << (WORD_ADDR_WIDTH + 2)) - 32'h1) | 32'h3;

    // Registered state
    owner_e     resp_owner_q, resp_owner_d;
    logic       resp_fault_q, resp_fault_d;
    logic       resp_we_q,    resp_we_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Arbitration and address check
    logic f_addr_fault;
    logic l_addr_fault;
    logic l_wins;
    logic f_gnt_c;
    logic l_gnt_c;

    always_comb begin
        f_addr_fault = |(bus.f_addr & FAULT_MASK);
        l_addr_fault = |(bus.l_addr & FAULT_MASK);
        l_wins       = bus.l_req && (!bus.f_req || (starve_cnt_q == STARVE_MAX));
        f_gnt_c      = rst_n && bus.f_req && !l_wins;
        l_gnt_c      = rst_n && bus.l_req && l_wins;
    end

    // Memory strobe: a faulting grant is acknowledged but never reaches the array.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves a latch.
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (f_gnt_c && !f_addr_fault) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.f_addr[WORD_ADDR_WIDTH+1:2];
            bus.mem_wdata = bus.l_wdata;
        end else if (l_gnt_c && !l_addr_fault) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.l_we;
            bus.mem_addr  = bus.l_addr[WORD_ADDR_WIDTH+1:2];
            bus.mem_wdata = bus.l_wdata;
        end
    end

    assign bus.f_gnt = f_gnt_c;
    assign bus.l_gnt = l_gnt_c;

    // Next-state: response owner and starvation count
    always_comb begin
        resp_owner_d = OWN_NONE;
        resp_fault_d = 1'b0;
        resp_we_d    = 1'b0;
        if (f_gnt_c) begin
            resp_owner_d = OWN_FETCH;
            resp_fault_d = f_addr_fault;
        end else if (l_gnt_c) begin
            resp_owner_d = OWN_LOAD;
            resp_fault_d = l_addr_fault;
            resp_we_d    = bus.l_we;
        end

        starve_cnt_d = starve_cnt_q;
        if (l_gnt_c) begin
            starve_cnt_d = 4'd0;
        end else if (bus.l_req && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            resp_owner_q <= OWN_NONE;
            resp_fault_q <= 1'b0;
            resp_we_q    <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            resp_owner_q <= resp_owner_d;
            resp_fault_q <= resp_fault_d;
            resp_we_q    <= resp_we_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response stage: data comes straight from the array one cycle after the strobe.
    logic f_resp;
    logic l_resp;

    always_comb begin
        f_resp       = rst_n && (resp_owner_q == OWN_FETCH) && !bus.f_flush;
        l_resp       = rst_n && (resp_owner_q == OWN_LOAD);

        bus.f_rvalid = f_resp;
        bus.f_fault  = f_resp && resp_fault_q;
        bus.f_rdata  = (f_resp && !resp_fault_q) ? bus.mem_rdata : '0;

        bus.l_rvalid = l_resp;
        bus.l_fault  = l_resp && resp_fault_q;
        bus.l_rdata  = (l_resp && !resp_fault_q && !resp_we_q) ? bus.mem_rdata : '0;
    end

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(f_gnt_c && !f_addr_fault);
        perf_stall_d = perf_stall_q + 32'(bus.f_req && !f_gnt_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and sequencer for the single-port, word-addressed instruction memory. It shares the memory between the core's fetch port and the program-loader/debug port. Each access gets a 1-cycle-latency response, and misaligned or out-of-window addresses are reported as faults rather than driven onto the bus. It sits between the fetch stage, the loader and the IMEM array.

## Interface
- `WORD_ADDR_WIDTH`, 18: memory word-address width. Depth is 2^18 words and the byte window is 0x0000_0000–0x000F_FFFF.
- `DATA_WIDTH`, 32: instruction/data word width.
- `STARVE_LIMIT`, 4: number of consecutive lost contentions after which the loader wins. Legal range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `f_req` in 1: fetch request.
- `f_addr` in 32: fetch byte address.
- `f_flush` in 1: discard any fetch response due next cycle.
- `f_gnt` out 1: fetch request accepted this cycle.
- `f_rvalid` out 1: fetch response valid.
- `f_rdata` out 32: fetched instruction.
- `f_fault` out 1: fetch response is a fault.
- `l_req` in 1: loader request.
- `l_we` in 1: loader write (1) or read (0).
- `l_addr` in 32: loader byte address.
- `l_wdata` in 32: loader write data.
- `l_gnt` out 1: loader request accepted.
- `l_rvalid` out 1: loader response/ack valid.
- `l_rdata` out 32: loader read data.
- `l_fault` out 1: loader response is a fault.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 18: word address, equal to `addr[19:2]`.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en`.

## Operation
- One access per cycle. Arbitration is combinational on the current request lines and the starvation state.
- Priority: fetch wins by default. The loader wins when `f_req`=0, or when `starve_cnt` == `STARVE_LIMIT`.
- `starve_cnt` (4-bit):
  - +1 each cycle `l_req`=1 and `l_gnt`=0.
  - Cleared on `l_gnt`.
  - Saturates at `STARVE_LIMIT`.
- Address check on the granted request:
  - Fault if `addr[1:0]`≠0 or `addr[31:20]`≠0.
  - A faulting grant still asserts `gnt`, but `mem_en`=0.
  - Its response has `fault`=1 and `rdata`=0.
- Non-faulting grant: `mem_en`=1, `mem_addr`=`addr[19:2]`, `mem_we`=`l_we` for the loader and 0 for fetch, `mem_wdata`=`l_wdata`.
- Response pipeline register `resp_owner` ∈ {NONE, FETCH, LOAD} plus a fault bit. This is the state machine:
  - NONE→FETCH/LOAD on grant.
  - Remains FETCH/LOAD on back-to-back grants.
  - Returns to NONE when there is no grant.
- Response cycle:
  - FETCH: `f_rvalid`=1, `f_rdata`=`mem_rdata` (0 on fault).
  - LOAD read: `l_rdata`=`mem_rdata`.
  - LOAD write: `l_rvalid`=1 as an ack, `l_rdata`=0.
- `f_flush`=1 in the response cycle forces `f_rvalid`=0 and `f_fault`=0. A fetch granted in that same cycle is unaffected.
- The loader is never flushed.

## Timing
- Grant: same cycle as the request (combinational).
- Response: exactly 1 cycle after the grant. Full throughput: one grant per cycle, responses back to back.
- Requesters hold address/data only in the grant cycle. A request without a grant must be held by the requester.
- Reset values (registered outputs and state): `f_rvalid`, `f_fault`, `l_rvalid`, `l_fault`=0; `f_rdata`, `l_rdata`=0; `starve_cnt`=0; `resp_owner`=NONE.
- The combinational outputs `f_gnt`, `l_gnt` and `mem_*` are forced to 0 while `rst_n`=0.
- Reset mid-operation: a pending response is dropped, with no `rvalid` in the cycle after reset is released.
- Simultaneous `f_req` and `l_req` with `starve_cnt`<`STARVE_LIMIT`: fetch is granted and `starve_cnt`+1.
- At `STARVE_LIMIT`, the loader is granted and the count clears.
- Simultaneous loader write and fetch to the same word: there is no hazard, because only one access is granted per cycle.

## Configuration
- `IMEM_ARB_PERF_EN` defined adds two output ports:
  - `perf_fetch_cnt` [31:0]: counts non-faulting fetch grants.
  - `perf_stall_cnt` [31:0]: counts cycles with `f_req`=1 and `f_gnt`=0.
  - Both are cleared by reset and wrap at 2^32.
- Without the macro, the ports and counters are absent and the behaviour is otherwise identical.

## Test plan
- Reset release, then `f_req`=1, `f_addr`=0x0000_0008, memory word 2=0x0010_0093 → `f_gnt` the same cycle; next cycle `f_rvalid`=1, `f_rdata`=0x0010_0093, `f_fault`=0.
- `f_addr`=0x0000_0006, then 0x0010_0000 → `f_gnt`=1, `mem_en`=0; next cycle `f_rvalid`=1, `f_fault`=1, `f_rdata`=0.
- `f_req` and `l_req` held continuously, `STARVE_LIMIT`=4 → fetch is granted 4 cycles, the loader on the 5th, and the pattern repeats. `starve_cnt` reads 0 after the loader grant.
- Loader write 0xDEAD_BEEF to 0x40, then fetch 0x40 → `l_rvalid` ack with `l_rdata`=0; the fetch returns 0xDEAD_BEEF.
- Fetch granted at cycle n, `f_flush`=1 at n+1 together with a new fetch → no `f_rvalid` at n+1; the new fetch response appears at n+2.
- `rst_n`=0 in the cycle after a loader read grant → no `l_rvalid` after reset is released; all outputs are 0 during reset.
